// File: rtl/neuron_pkg.sv
// neuron_pkg: shared types, constants and helpers for the LIF neuron core.
//   state_e      - sequencer states of the time-multiplexed neuron update
//   weight_t     - 16-bit signed synaptic weight
//   potential_t  - 16-bit signed membrane potential
//   Pkt*Lsb      - bit offsets of the fields inside the 32-bit spike packet
//   sat_add      - 16-bit signed add that saturates instead of wrapping
package neuron_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLeak,
        StInteg,
        StFire,
        StLearn,
        StNext
    } state_e;

    typedef logic signed [15:0] weight_t;
    typedef logic signed [15:0] potential_t;

    // Spike packet: {X_ID, Y_ID, step, neuron index}
    localparam int unsigned PktXLsb    = 24;
    localparam int unsigned PktYLsb    = 16;
    localparam int unsigned PktStepLsb = 8;
    localparam int unsigned PktNurnLsb = 0;

    function automatic potential_t sat_add(input potential_t a, input weight_t b);
        logic [16:0] sum;
        sum = {a[15], a} + {b[15], b};
        // Overflow when the sign bit disagrees with the extension bit
        if (sum[16] != sum[15]) begin
            return sum[16] ? 16'sh8000 : 16'sh7fff;
        end
        return potential_t'(sum[15:0]);
    endfunction

endpackage

// File: rtl/stdp_update.sv
// stdp_update: combinational STDP weight update for one synapse.
//   w_i   - current weight
//   pre_i - latched pre-synaptic spike bit of this axon
//   w_o   - potentiated (pre=1, +A_PLUS) or depressed (pre=0, -A_MINUS) weight,
//           clamped to [W_MIN, W_MAX]
module stdp_update
    import neuron_pkg::*;
#(
    parameter int A_PLUS  = 16,
    parameter int A_MINUS = 8,
    parameter int W_MIN   = 0,
    parameter int W_MAX   = 1023
) (
    input  weight_t w_i,
    input  logic    pre_i,
    output weight_t w_o
);

    // Two guard bits so the raw sum cannot wrap before clamping
    logic signed [17:0] sum;

    always_comb begin
        if (pre_i) begin
            sum = 18'(w_i) + 18'(A_PLUS);
        end else begin
            sum = 18'(w_i) - 18'(A_MINUS);
        end

        if (sum < 18'(W_MIN)) begin
            w_o = weight_t'(W_MIN);
        end else if (sum > 18'(W_MAX)) begin
            w_o = weight_t'(W_MAX);
        end else begin
            w_o = weight_t'(sum[15:0]);
        end
    end

endmodule

// File: rtl/neuron.sv
// neuron: time-multiplexed leaky integrate-and-fire core with on-line STDP.
//   clk         - clock
//   rst_n       - asynchronous active-low reset
//   start       - one-cycle time-step trigger, honoured only while idle
//   inSpike     - axon spike vector, latched when start is accepted
//   outSpike    - one-cycle pulse for every neuron that fires
//   SpikePacket - {X_ID, Y_ID, step, neuron index}, held until the next fire
// Every step leaks, integrates and thresholds each neuron in index order; a
// firing neuron updates its axon weights while the step counter <= STOP_STEP.
// Optional macro DUMP_MEMORY_EN: in simulation, reports the weight table
// (<SIM_PATH>/weights_step<step>.txt) at the end of every step. Behaviour is
// otherwise identical with or without it.
module neuron
    import neuron_pkg::*;
#(
    parameter int unsigned NUM_NURNS          = 4,
    parameter int unsigned NUM_AXONS          = 4,
    parameter int unsigned NURN_CNT_BIT_WIDTH = 2,
    parameter int unsigned AXON_CNT_BIT_WIDTH = 2,
    parameter logic [7:0]  X_ID               = 8'd1,
    parameter logic [7:0]  Y_ID               = 8'd1,
    parameter int unsigned STOP_STEP          = 5,
    parameter string       SIM_PATH           = "",
    parameter int          INIT_WEIGHT        = 256,
    parameter int          THRESHOLD          = 768,
    parameter int unsigned LEAK_SHIFT         = 3,
    parameter int          A_PLUS             = 16,
    parameter int          A_MINUS            = 8,
    parameter int          W_MIN              = 0,
    parameter int          W_MAX              = 1023
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [NUM_AXONS-1:0] inSpike,
    output logic                 outSpike,
    output logic [31:0]          SpikePacket
);

    localparam logic [NURN_CNT_BIT_WIDTH-1:0] LastNurn = NURN_CNT_BIT_WIDTH'(NUM_NURNS - 1);
    localparam logic [AXON_CNT_BIT_WIDTH-1:0] LastAxon = AXON_CNT_BIT_WIDTH'(NUM_AXONS - 1);

    state_e                        state_q, state_d;
    logic [NUM_AXONS-1:0]          spike_q, spike_d;
    logic [7:0]                    step_q, step_d;
    logic [NURN_CNT_BIT_WIDTH-1:0] nurn_q, nurn_d;
    logic [AXON_CNT_BIT_WIDTH-1:0] axon_q, axon_d;
    potential_t                    v_q [NUM_NURNS];
    potential_t                    v_d [NUM_NURNS];
    weight_t                       w_q [NUM_NURNS][NUM_AXONS];
    weight_t                       w_d [NUM_NURNS][NUM_AXONS];
    logic                          out_spike_q, out_spike_d;
    logic [31:0]                   packet_q, packet_d;

    potential_t cur_v;
    weight_t    cur_w;
    weight_t    learn_w;
    logic       learn_en;
    logic       last_axon;
    logic       last_nurn;

    assign cur_v     = v_q[nurn_q];
    assign cur_w     = w_q[nurn_q][axon_q];
    assign learn_en  = (32'(step_q) <= STOP_STEP);
    assign last_axon = (axon_q == LastAxon);
    assign last_nurn = (nurn_q == LastNurn);

    stdp_update #(
        .A_PLUS  (A_PLUS),
        .A_MINUS (A_MINUS),
        .W_MIN   (W_MIN),
        .W_MAX   (W_MAX)
    ) u_stdp_update (
        .w_i   (cur_w),
        .pre_i (spike_q[axon_q]),
        .w_o   (learn_w)
    );

    always_comb begin
        state_d     = state_q;
        spike_d     = spike_q;
        step_d      = step_q;
        nurn_d      = nurn_q;
        axon_d      = axon_q;
        v_d         = v_q;
        w_d         = w_q;
        out_spike_d = 1'b0;
        packet_d    = packet_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    spike_d = inSpike;
                    step_d  = step_q + 8'd1;
                    nurn_d  = '0;
                    axon_d  = '0;
                    state_d = StLeak;
                end
            end
            StLeak: begin
                v_d[nurn_q] = cur_v - (cur_v >>> LEAK_SHIFT);
                axon_d      = '0;
                state_d     = StInteg;
            end
            StInteg: begin
                if (spike_q[axon_q]) begin
                    v_d[nurn_q] = sat_add(cur_v, cur_w);
                end
                if (last_axon) begin
                    axon_d  = '0;
                    state_d = StFire;
                end else begin
                    axon_d = axon_q + AXON_CNT_BIT_WIDTH'(1);
                end
            end
            StFire: begin
                if (cur_v >= THRESHOLD) begin
                    out_spike_d                    = 1'b1;
                    packet_d[PktXLsb +: 8]    = X_ID;
                    packet_d[PktYLsb +: 8]    = Y_ID;
                    packet_d[PktStepLsb +: 8] = step_q;
                    packet_d[PktNurnLsb +: 8] = 8'(nurn_q);
                    v_d[nurn_q]                    = '0;
                    state_d                        = learn_en ? StLearn : StNext;
                end else begin
                    state_d = StNext;
                end
                axon_d = '0;
            end
            StLearn: begin
                w_d[nurn_q][axon_q] = learn_w;
                if (last_axon) begin
                    axon_d  = '0;
                    state_d = StNext;
                end else begin
                    axon_d = axon_q + AXON_CNT_BIT_WIDTH'(1);
                end
            end
            StNext: begin
                if (last_nurn) begin
                    state_d = StIdle;
                end else begin
                    nurn_d  = nurn_q + NURN_CNT_BIT_WIDTH'(1);
                    state_d = StLeak;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            spike_q     <= '0;
            step_q      <= '0;
            nurn_q      <= '0;
            axon_q      <= '0;
            out_spike_q <= 1'b0;
            packet_q    <= '0;
            for (int n = 0; n < int'(NUM_NURNS); n++) begin
                v_q[n] <= '0;
                for (int a = 0; a < int'(NUM_AXONS); a++) begin
                    w_q[n][a] <= weight_t'(INIT_WEIGHT);
                end
            end
        end else begin
            state_q     <= state_d;
            spike_q     <= spike_d;
            step_q      <= step_d;
            nurn_q      <= nurn_d;
            axon_q      <= axon_d;
            out_spike_q <= out_spike_d;
            packet_q    <= packet_d;
            v_q         <= v_d;
            w_q         <= w_d;
        end
    end

    assign outSpike    = out_spike_q;
    assign SpikePacket = packet_q;

`ifdef DUMP_MEMORY_EN
    // Weights are final by the NEXT state of the last neuron, so dump on that edge
    always @(posedge clk) begin
        if (rst_n && state_q == StNext && last_nurn) begin
            string line;
            $display("%s/weights_step%0d.txt", SIM_PATH, step_q);
            for (int n = 0; n < int'(NUM_NURNS); n++) begin
                line = "";
                for (int a = 0; a < int'(NUM_AXONS); a++) begin
                    line = {line, $sformatf("%04h ", w_q[n][a])};
                end
                $display("%s", line);
            end
        end
    end
`endif

endmodule

// File: tb/tb_neuron.sv
// tb_neuron: directed plus randomized steps checked against a step-level
// behavioural model of the neuron core (potentials, weights, spike packets
// and the cycle at which each outSpike pulse must appear).
module tb_neuron;
    import neuron_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  inSpike;
    logic        outSpike;
    logic [31:0] SpikePacket;

    neuron dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .inSpike     (inSpike),
        .outSpike    (outSpike),
        .SpikePacket (SpikePacket)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        logic [31:0] pkt;
    } spk_t;

    spk_t got_q[$];
    spk_t exp_q[$];

    always @(negedge clk) begin
        if (outSpike) got_q.push_back('{cyc, SpikePacket});
    end

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state
    int mv [4];
    int mw [4][4];
    int mstep;
    int snap [4][4];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mstep = 0;
        for (int n = 0; n < 4; n++) begin
            mv[n] = 0;
            for (int a = 0; a < 4; a++) mw[n][a] = 256;
        end
    endtask

    task automatic check_state(input string tag);
        for (int n = 0; n < 4; n++) begin
            check($sformatf("%s_v%0d", tag, n), 64'(dut.v_q[n]), 64'(mv[n]));
            for (int a = 0; a < 4; a++) begin
                check($sformatf("%s_w%0d%0d", tag, n, a), 64'(dut.w_q[n][a]), 64'(mw[n][a]));
            end
        end
    endtask

    // One full time step: drive start, predict with the model, compare pulses
    task automatic run_step(input logic [3:0] spikes, input bit poke);
        int  k;
        int  off;
        bit  learn;
        got_q.delete();
        exp_q.delete();
        @(negedge clk);
        inSpike = spikes;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        inSpike = 4'($urandom);  // must not disturb the latched vector
        k       = cyc;

        mstep = (mstep + 1) % 256;
        learn = (mstep <= 5);
        off   = 0;
        for (int n = 0; n < 4; n++) begin
            mv[n] = mv[n] - (mv[n] >>> 3);
            for (int a = 0; a < 4; a++) begin
                if (spikes[a]) mv[n] = mv[n] + mw[n][a];
                if (mv[n] > 32767) mv[n] = 32767;
                if (mv[n] < -32768) mv[n] = -32768;
            end
            if (mv[n] >= 768) begin
                exp_q.push_back('{k + off + 6, {8'd1, 8'd1, 8'(mstep), 8'(n)}});
                mv[n] = 0;
                if (learn) begin
                    for (int a = 0; a < 4; a++) begin
                        mw[n][a] = spikes[a] ? mw[n][a] + 16 : mw[n][a] - 8;
                        if (mw[n][a] > 1023) mw[n][a] = 1023;
                        if (mw[n][a] < 0) mw[n][a] = 0;
                    end
                    off += 4;
                end
            end
            off += 7;
        end

        if (poke) begin
            repeat (4) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end

        while (cyc < k + off + 1) @(negedge clk);
        check($sformatf("s%0d_idle", mstep), 64'(dut.state_q), 64'(StIdle));
        check($sformatf("s%0d_nspk", mstep), 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("s%0d_pkt%0d", mstep, i), 64'(got_q[i].pkt), 64'(exp_q[i].pkt));
            check($sformatf("s%0d_cyc%0d", mstep, i), 64'(got_q[i].cyc - k),
                  64'(exp_q[i].cyc - k));
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int       found;
        logic [3:0] rs;

        rst_n   = 1'b0;
        start   = 1'b0;
        inSpike = 4'h0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_out", 64'(outSpike), 64'd0);
        check("rst_pkt", 64'(SpikePacket), 64'd0);
        check("rst_step", 64'(dut.step_q), 64'd0);
        check("rst_state", 64'(dut.state_q), 64'(StIdle));
        check_state("rst");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Step 1: all neurons reach 1024 and fire, weights go to 272
        run_step(4'b1111, 1'b0);
        check("s1_count", 64'(got_q.size()), 64'd4);
        check("s1_last_pkt", 64'(got_q.size() > 0 ? got_q[got_q.size() - 1].pkt : 32'h0),
              64'h01010103);
        check("s1_w", 64'(dut.w_q[2][1]), 64'd272);
        check_state("s1");

        // Step 2: v = 272, no fire
        run_step(4'b0010, 1'b0);
        check("s2_count", 64'(got_q.size()), 64'd0);
        check("s2_v", 64'(dut.v_q[3]), 64'd272);
        check_state("s2");

        // Step 3: v = 782, all fire, mixed potentiation/depression
        run_step(4'b0110, 1'b0);
        check("s3_w1", 64'(dut.w_q[0][1]), 64'd288);
        check("s3_w2", 64'(dut.w_q[3][2]), 64'd288);
        check("s3_w0", 64'(dut.w_q[1][0]), 64'd264);
        check("s3_w3", 64'(dut.w_q[2][3]), 64'd264);
        check_state("s3");

        // Step 4 with a stray start mid-step that must be ignored
        run_step(4'b1111, 1'b1);
        check("s4_step", 64'(dut.step_q), 64'd4);
        run_step(4'b1111, 1'b0);
        check("s5_step", 64'(dut.step_q), 64'd5);
        for (int n = 0; n < 4; n++)
            for (int a = 0; a < 4; a++) snap[n][a] = mw[n][a];

        // Step 6: fires but learning is frozen
        run_step(4'b1111, 1'b0);
        check("s6_count", 64'(got_q.size()), 64'd4);
        for (int n = 0; n < 4; n++)
            for (int a = 0; a < 4; a++)
                check($sformatf("s6_frozen%0d%0d", n, a), 64'(dut.w_q[n][a]), 64'(snap[n][a]));

        // Random steps, long enough to wrap the step counter and relearn
        for (int i = 0; i < 256; i++) begin
            rs = 4'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            run_step(rs, 1'($urandom_range(0, 7) == 0));
        end
        check_state("rand");

        // Reset during INTEG of neuron 2
        @(negedge clk);
        inSpike = 4'b1111;
        start   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        found   = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            if (dut.state_q == StInteg && dut.nurn_q == 2'd2) found = 1;
            else @(negedge clk);
        end
        check("mid_found", 64'(found), 64'd1);
        rst_n = 1'b0;
        #1;
        got_q.delete();
        model_reset();
        check("mid_out", 64'(outSpike), 64'd0);
        check("mid_pkt", 64'(SpikePacket), 64'd0);
        check("mid_step", 64'(dut.step_q), 64'd0);
        check("mid_state", 64'(dut.state_q), 64'(StIdle));
        check_state("mid");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        check("mid_nopkt", 64'(got_q.size()), 64'd0);

        // First step after reset behaves like step 1
        run_step(4'b1111, 1'b0);
        check("post_count", 64'(got_q.size()), 64'd4);
        check_state("post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
